// File: rtl/secure_regfile_scrub.sv
// Multi-read-port register file with a sequential scrub engine that overwrites
// every entry after reset or a zeroize request; writes rejected and reads masked while scrubbing.
//
// Request semantics: wr_en_i, rd_en_i and zeroize_req_i are single-cycle
// requests sampled on the rising clk edge with no ready/backpressure. A write is
// accepted only in IDLE without a concurrent zeroize; otherwise wr_err_o pulses.
// rd_valid_o[p] qualifies rd_data_o for port p one cycle after its request.
module secure_regfile_scrub #(
  parameter int                 DATA_W    = 32,
  parameter int                 ADDR_W    = 4,
  parameter int                 NUM_RD    = 2,
  parameter logic [DATA_W-1:0]  SCRUB_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en_i,
  input  logic [ADDR_W-1:0]          wr_addr_i,
  input  logic [DATA_W-1:0]          wr_data_i,
  input  logic [NUM_RD-1:0]          rd_en_i,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0]   rd_data_o,
  output logic [NUM_RD-1:0]          rd_valid_o,
  input  logic                       zeroize_req_i,
  output logic                       busy_o,
  output logic                       scrub_done_o,
  output logic                       wr_err_o,
  output logic                       dbg_state_o
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    ST_SCRUB = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  state_e                     state_q, state_d;
  logic [ADDR_W-1:0]          scrub_idx_q, scrub_idx_d;
  logic [DATA_W-1:0]          mem_q [DEPTH];
  logic [NUM_RD*DATA_W-1:0]   rd_data_q, rd_data_d;
  logic [NUM_RD-1:0]          rd_valid_q, rd_valid_d;
  logic                       scrub_done_q, scrub_done_d;
  logic                       wr_err_q, wr_err_d;

  logic scrub_last;
  logic zeroize_start;
  logic wr_accept;

  // The terminal index ends the sweep, so the counter never starts a second pass.
  assign scrub_last    = (state_q == ST_SCRUB) && (scrub_idx_q == {ADDR_W{1'b1}});
  assign zeroize_start = (state_q == ST_IDLE) && zeroize_req_i;
  assign wr_accept     = (state_q == ST_IDLE) && wr_en_i && !zeroize_req_i;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_SCRUB;
      scrub_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      scrub_idx_q <= scrub_idx_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d     = state_q;
    scrub_idx_d = scrub_idx_q;
    case (state_q)
      ST_SCRUB: begin
        scrub_idx_d = scrub_idx_q + ADDR_W'(1);
        if (scrub_last) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (zeroize_req_i) begin
          state_d     = ST_SCRUB;
          scrub_idx_d = '0;
        end
      end
      default: begin
        state_d     = ST_SCRUB;
        scrub_idx_d = '0;
      end
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy_o      = (state_q == ST_SCRUB);
    dbg_state_o = state_q;
  end

  // ---------------------------------------------------------------------------
  // Storage: no direct reset; the sweep is the only way contents are cleared.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == ST_SCRUB) begin
        mem_q[scrub_idx_q] <= SCRUB_VAL;
      end else if (wr_accept) begin
        mem_q[wr_addr_i] <= wr_data_i;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports: registered, read-before-write against the array
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = '0;
    if ((state_q == ST_SCRUB) || zeroize_start) begin
      rd_data_d = '0;
    end else begin
      for (int p = 0; p < NUM_RD; p++) begin
        if (rd_en_i[p]) begin
          rd_data_d[p*DATA_W +: DATA_W] = mem_q[rd_addr_i[p*ADDR_W +: ADDR_W]];
          rd_valid_d[p]                 = 1'b1;
        end
      end
    end
  end

  // Status pulses
  always_comb begin
    scrub_done_d = scrub_last;
    wr_err_d     = wr_en_i && !wr_accept;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q    <= '0;
      rd_valid_q   <= '0;
      scrub_done_q <= 1'b0;
      wr_err_q     <= 1'b0;
    end else begin
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
      scrub_done_q <= scrub_done_d;
      wr_err_q     <= wr_err_d;
    end
  end

  assign rd_data_o    = rd_data_q;
  assign rd_valid_o   = rd_valid_q;
  assign scrub_done_o = scrub_done_q;
  assign wr_err_o     = wr_err_q;

endmodule

// File: tb/tb_secure_regfile_scrub.sv
// Directed bench for secure_regfile_scrub: reset sweep, read latency, zeroize,
// collisions, reset mid-scrub and zeroize/write contention.
module tb_secure_regfile_scrub;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int NUM_RD = 2;
  localparam int DEPTH  = 16;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                       rst;
  logic                       wr_en;
  logic [ADDR_W-1:0]          wr_addr;
  logic [DATA_W-1:0]          wr_data;
  logic [NUM_RD-1:0]          rd_en;
  logic [NUM_RD*ADDR_W-1:0]   rd_addr;
  logic [NUM_RD*DATA_W-1:0]   rd_data;
  logic [NUM_RD-1:0]          rd_valid;
  logic                       zeroize_req;
  logic                       busy;
  logic                       scrub_done;
  logic                       wr_err;
  logic                       dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [DATA_W-1:0] exp_q[$];

  secure_regfile_scrub #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .SCRUB_VAL('0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en_i      (wr_en),
    .wr_addr_i    (wr_addr),
    .wr_data_i    (wr_data),
    .rd_en_i      (rd_en),
    .rd_addr_i    (rd_addr),
    .rd_data_o    (rd_data),
    .rd_valid_o   (rd_valid),
    .zeroize_req_i(zeroize_req),
    .busy_o       (busy),
    .scrub_done_o (scrub_done),
    .wr_err_o     (wr_err),
    .dbg_state_o  (dbg_state)
  );

  // Driver tasks: inputs change on negedge, outputs are sampled on negedge.
  task automatic tick;
    @(negedge clk);
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_read2(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
    rd_en = 2'b11; rd_addr = {a1, a0};
    tick();
    rd_en = 2'b00;
  endtask

  task automatic wait_idle(input int budget);
    int c;
    c = 0;
    while (busy === 1'b1 && c < budget) begin
      tick();
      c++;
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, c);
    end
  endtask

  // Scoreboard sweep: both ports read every entry, expected value from exp_q.
  task automatic sweep_expect(input logic [DATA_W-1:0] v, input string tag);
    logic [DATA_W-1:0] e0, e1;
    for (int i = 0; i < DEPTH; i++) begin
      exp_q.push_back(v);
      exp_q.push_back(v);
      do_read2(ADDR_W'(i), ADDR_W'(DEPTH - 1 - i));
      e0 = exp_q.pop_front();
      e1 = exp_q.pop_front();
      n_cmp++;
      if (rd_data !== {e1, e0} || rd_valid !== 2'b11) begin
        n_fail++;
        $display("FAIL %s addr %0d: data=%h valid=%b, required %h valid=11",
                 tag, i, rd_data, rd_valid, {e1, e0});
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || rd_valid !== 2'b00 || rd_data !== '0 ||
        scrub_done !== 1'b0 || wr_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b valid=%b data=%h done=%b err=%b, required 1 00 0 0 0",
               busy, rd_valid, rd_data, scrub_done, wr_err);
    end
    for (int c = 2; c <= 16; c++) begin
      tick();
      n_cmp++;
      if (busy !== 1'b1 || scrub_done !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_busy cycle %0d: busy=%b done=%b, required 1 0", c, busy, scrub_done);
      end
    end
    tick();
    n_cmp++;
    if (busy !== 1'b0 || scrub_done !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_done cycle 17: busy=%b done=%b, required 0 1", busy, scrub_done);
    end
    tick();
    n_cmp++;
    if (busy !== 1'b0 || scrub_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_after: busy=%b done=%b, required 0 0", busy, scrub_done);
    end
    sweep_expect(32'h0000_0000, "reset_sweep");
  endtask

  task automatic test_write_read;
    do_write(4'd5, 32'hDEAD_BEEF);
    rd_en = 2'b01; rd_addr = {4'd0, 4'd5};
    tick();
    rd_en = 2'b00;
    n_cmp++;
    if (rd_data[31:0] !== 32'hDEAD_BEEF || rd_valid !== 2'b01 || rd_data[63:32] !== 32'h0) begin
      n_fail++;
      $display("FAIL write_read: data=%h valid=%b, required 00000000deadbeef valid=01",
               rd_data, rd_valid);
    end
    tick();
    n_cmp++;
    if (rd_valid !== 2'b00 || rd_data[31:0] !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL read_hold: data=%h valid=%b, required deadbeef valid=00",
               rd_data[31:0], rd_valid);
    end
  endtask

  task automatic test_zeroize;
    for (int i = 0; i < DEPTH; i++) do_write(ADDR_W'(i), 32'hA5A5_A5A5);
    do_read2(4'd1, 4'd2);
    n_cmp++;
    if (rd_data !== {2{32'hA5A5_A5A5}} || rd_valid !== 2'b11) begin
      n_fail++;
      $display("FAIL zeroize_fill: data=%h valid=%b, required a5a5a5a5a5a5a5a5 11", rd_data, rd_valid);
    end
    zeroize_req = 1'b1;
    tick();
    zeroize_req = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || rd_data !== '0 || rd_valid !== 2'b00) begin
      n_fail++;
      $display("FAIL zeroize_entry: busy=%b data=%h valid=%b, required 1 0 00", busy, rd_data, rd_valid);
    end
    for (int c = 0; c < 4; c++) tick();
    do_write(4'd0, 32'h1234_5678);
    n_cmp++;
    if (wr_err !== 1'b1) begin
      n_fail++;
      $display("FAIL scrub_wr_err: wr_err=%b, required 1", wr_err);
    end
    do_read2(4'd0, 4'd15);
    n_cmp++;
    if (wr_err !== 1'b0 || rd_data !== '0 || rd_valid !== 2'b00) begin
      n_fail++;
      $display("FAIL scrub_read_mask: err=%b data=%h valid=%b, required 0 0 00", wr_err, rd_data, rd_valid);
    end
    wait_idle(40);
    n_cmp++;
    if (scrub_done !== 1'b1) begin
      n_fail++;
      $display("FAIL zeroize_done: scrub_done=%b, required 1", scrub_done);
    end
    sweep_expect(32'h0000_0000, "zeroize_sweep");
  endtask

  task automatic test_collision;
    do_write(4'd3, 32'h1111_1111);
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'h2222_2222;
    rd_en = 2'b11; rd_addr = {4'd3, 4'd3};
    tick();
    wr_en = 1'b0; rd_en = 2'b00;
    n_cmp++;
    if (rd_data !== {2{32'h1111_1111}} || rd_valid !== 2'b11) begin
      n_fail++;
      $display("FAIL collision_old: data=%h valid=%b, required 1111111111111111 11", rd_data, rd_valid);
    end
    do_read2(4'd3, 4'd3);
    n_cmp++;
    if (rd_data !== {2{32'h2222_2222}} || rd_valid !== 2'b11) begin
      n_fail++;
      $display("FAIL collision_new: data=%h valid=%b, required 2222222222222222 11", rd_data, rd_valid);
    end
    tick();
    n_cmp++;
    if (rd_data !== {2{32'h2222_2222}} || rd_valid !== 2'b00) begin
      n_fail++;
      $display("FAIL collision_hold: data=%h valid=%b, required 2222222222222222 00", rd_data, rd_valid);
    end
  endtask

  task automatic test_reset_mid_scrub;
    int pulses;
    pulses = 0;
    zeroize_req = 1'b1;
    tick();
    zeroize_req = 1'b0;
    for (int c = 0; c < 9; c++) begin
      tick();
      if (scrub_done === 1'b1) pulses++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      n_cmp++;
      if (busy !== 1'b1 || scrub_done !== 1'b0) begin
        n_fail++;
        $display("FAIL midrst_busy cycle %0d: busy=%b done=%b, required 1 0", c, busy, scrub_done);
      end
      if (scrub_done === 1'b1) pulses++;
      tick();
    end
    n_cmp++;
    if (busy !== 1'b0 || scrub_done !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_done: busy=%b done=%b, required 0 1", busy, scrub_done);
    end
    if (scrub_done === 1'b1) pulses++;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (scrub_done === 1'b1) pulses++;
    end
    n_cmp++;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL midrst_pulses: count=%0d, required 1", pulses);
    end
  endtask

  task automatic test_zeroize_and_write;
    zeroize_req = 1'b1;
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'hCAFE_F00D;
    tick();
    zeroize_req = 1'b0; wr_en = 1'b0;
    n_cmp++;
    if (wr_err !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL zw_contention: wr_err=%b busy=%b, required 1 1", wr_err, busy);
    end
    wait_idle(40);
    do_read2(4'd7, 4'd7);
    n_cmp++;
    if (rd_data !== '0 || rd_valid !== 2'b11) begin
      n_fail++;
      $display("FAIL zw_readback: data=%h valid=%b, required 0 11", rd_data, rd_valid);
    end
  endtask

  initial begin
    rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_en = '0; rd_addr = '0; zeroize_req = 1'b0;
    tick();
    test_reset();
    test_write_read();
    test_zeroize();
    test_collision();
    test_reset_mid_scrub();
    test_zeroize_and_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
